// File: rtl/instrumented_adder_pkg.sv
// Shared types and timing constants for the instrumented adder measurement controller.
package instrumented_adder_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      RUN    = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int SETTLE_CYCLES = 4;
   localparam int DRAIN_CYCLES  = 2;
   localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/instrumented_adder_edge_sync.sv
// Multi-flop synchroniser for an asynchronous carry-chain output plus a
// one-cycle rising-edge pulse on the synchronised level.
module instrumented_adder_edge_sync
   import instrumented_adder_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/instrumented_adder_meas_ctrl.sv
// Ring-oscillator / single-shot latency measurement controller for NUM_CH adder channels.
// Define INSTR_ADDER_AVG_EN to average 2^AVG_LOG runs per start.
module instrumented_adder_meas_ctrl
   import instrumented_adder_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_CH  = 4,
   parameter int WIN_W   = 16,
   parameter int CNT_W   = 24,
`ifdef INSTR_ADDER_AVG_EN
   parameter int AVG_LOG = 2,
`endif
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [CH_W-1:0]   chan_sel,
   input  logic [WIDTH-1:0]  a_val,
   input  logic [WIDTH-1:0]  b_val,
   input  logic [WIN_W-1:0]  window,
   input  logic [NUM_CH-1:0] chain_in,
   input  logic [WIDTH-1:0]  s_in,
   output logic [WIDTH-1:0]  adder_a,
   output logic [WIDTH-1:0]  adder_b,
   output logic [NUM_CH-1:0] ring_en,
   output logic              ext_bit,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic [WIDTH-1:0]  sum_out,
   output logic              overflow,
   output logic [2:0]        dbg_state
);

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic [CH_W-1:0]    chan_q, chan_d, chan_fix;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [WIN_W-1:0]   win_q, win_d, tmr_q, tmr_d;
   logic [CNT_W-1:0]   cur_q, cur_d, count_q, count_d;
   logic               run_ovf_q, run_ovf_d, ovf_q, ovf_d, got_q, got_d;
   logic [NUM_CH-1:0]  ring_en_q, ring_en_d, chan_onehot;
   logic               ext_bit_q, ext_bit_d, done_q, done_d;
   logic               chain_sel, edge_pulse, last_run;
`ifdef INSTR_ADDER_AVG_EN
   localparam int ACC_W = CNT_W + AVG_LOG;
   logic [ACC_W-1:0]   acc_q, acc_d, acc_n;
   logic [AVG_LOG-1:0] run_idx_q, run_idx_d;
`endif

   // Out-of-range channel numbers fall back to channel 0.
   if ((1 << CH_W) > NUM_CH) begin : g_clamp
      assign chan_fix = (32'(chan_sel) >= 32'(NUM_CH)) ? '0 : chan_sel;
   end else begin : g_pass
      assign chan_fix = chan_sel;
   end

   assign chain_sel   = chain_in[chan_q];
   assign chan_onehot = NUM_CH'(1) << chan_q;

   instrumented_adder_edge_sync u_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n),
      .din   (chain_sel),
      .rise  (edge_pulse)
   );

   always_comb begin
      state_d   = state_q;    mode_d    = mode_q;    chan_d  = chan_q;
      a_d       = a_q;        b_d       = b_q;       win_d   = win_q;
      tmr_d     = tmr_q;      cur_d     = cur_q;     got_d   = got_q;
      run_ovf_d = run_ovf_q;  count_d   = count_q;   ovf_d   = ovf_q;
      sum_d     = sum_q;      ring_en_d = ring_en_q; ext_bit_d = ext_bit_q;
      done_d    = 1'b0;
      last_run  = 1'b1;
`ifdef INSTR_ADDER_AVG_EN
      acc_d     = acc_q;
      run_idx_d = run_idx_q;
      acc_n     = '0;
      last_run  = &run_idx_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d   = LOAD;
            mode_d    = mode;
            chan_d    = chan_fix;
            a_d       = a_val;
            b_d       = b_val;
            win_d     = (window == '0) ? WIN_W'(1) : window;
            cur_d     = '0;
            got_d     = 1'b0;
            run_ovf_d = 1'b0;
            count_d   = '0;
            ovf_d     = 1'b0;
`ifdef INSTR_ADDER_AVG_EN
            acc_d     = '0;
            run_idx_d = '0;
`endif
         end
         LOAD: begin
            state_d = SETTLE;
            tmr_d   = '0;
         end
         SETTLE: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == WIN_W'(SETTLE_CYCLES - 1)) begin
               state_d = RUN;
               tmr_d   = '0;
               sum_d   = s_in;
               if (mode_q) ext_bit_d = 1'b1;
               else        ring_en_d = chan_onehot;
            end
         end
         RUN: begin
            tmr_d = tmr_q + 1'b1;
            if (mode_q) begin
               if (edge_pulse && !got_q) begin
                  got_d = 1'b1;
                  cur_d = CNT_W'(tmr_q);
               end
            end else if (edge_pulse) begin
               if (&cur_q) run_ovf_d = 1'b1;
               else        cur_d = cur_q + 1'b1;
            end
            if (tmr_q == win_q - 1'b1) begin
               state_d = DRAIN;
               tmr_d   = '0;
               if (last_run) ring_en_d = '0;
               // No edge by the end of the window: report a timeout.
               if (mode_q && !got_q && !edge_pulse) begin
                  cur_d     = CNT_W'(win_q);
                  run_ovf_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            tmr_d = tmr_q + 1'b1;
            if (!mode_q && edge_pulse) begin
               if (&cur_q) run_ovf_d = 1'b1;
               else        cur_d = cur_q + 1'b1;
            end
            if (tmr_q == WIN_W'(DRAIN_CYCLES - 1)) begin
               tmr_d     = '0;
               ext_bit_d = 1'b0;
`ifdef INSTR_ADDER_AVG_EN
               acc_n = acc_q + ACC_W'(cur_d);
               if (last_run) begin
                  count_d = CNT_W'(acc_n >> AVG_LOG);
                  ovf_d   = run_ovf_d;
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  acc_d     = acc_n;
                  run_idx_d = run_idx_q + 1'b1;
                  cur_d     = '0;
                  got_d     = 1'b0;
                  state_d   = SETTLE;
               end
`else
               count_d = cur_d;
               ovf_d   = run_ovf_d;
               state_d = DONE;
               done_d  = 1'b1;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q   <= IDLE;  mode_q  <= 1'b0; chan_q  <= '0;
         a_q       <= '0;    b_q     <= '0;   win_q   <= '0;
         tmr_q     <= '0;    cur_q   <= '0;   got_q   <= 1'b0;
         run_ovf_q <= 1'b0;  count_q <= '0;   ovf_q   <= 1'b0;
         sum_q     <= '0;    ring_en_q <= '0; ext_bit_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef INSTR_ADDER_AVG_EN
         acc_q     <= '0;
         run_idx_q <= '0;
`endif
      end else begin
         state_q   <= state_d;   mode_q  <= mode_d;  chan_q  <= chan_d;
         a_q       <= a_d;       b_q     <= b_d;     win_q   <= win_d;
         tmr_q     <= tmr_d;     cur_q   <= cur_d;   got_q   <= got_d;
         run_ovf_q <= run_ovf_d; count_q <= count_d; ovf_q   <= ovf_d;
         sum_q     <= sum_d;     ring_en_q <= ring_en_d; ext_bit_q <= ext_bit_d;
         done_q    <= done_d;
`ifdef INSTR_ADDER_AVG_EN
         acc_q     <= acc_d;
         run_idx_q <= run_idx_d;
`endif
      end
   end

   assign adder_a   = a_q;
   assign adder_b   = b_q;
   assign ring_en   = ring_en_q;
   assign ext_bit   = ext_bit_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign count     = count_q;
   assign sum_out   = sum_q;
   assign overflow  = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_instrumented_adder_meas_ctrl.sv
// Directed bench for the measurement controller: a behavioural carry-chain model
// drives chain_in, expected results are queued at issue and checked on done.
module tb_instrumented_adder_meas_ctrl;
   import instrumented_adder_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [1:0]  chan_sel = '0;
   logic [31:0] a_val = '0, b_val = '0;
   logic [15:0] window = '0;
   logic [3:0]  chain_in = '0;
   logic [31:0] s_in;
   logic [31:0] adder_a, adder_b, sum_out;
   logic [3:0]  ring_en;
   logic        ext_bit, busy, done, overflow;
   logic [23:0] count;
   logic [2:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   // {tol[7:0], ovf, sum[31:0], cnt[23:0]}
   logic [64:0] exp_q[$];

   int ch_mode = 0;   // 0: stuck low, 1: ring toggler, 2: single-shot responder
   int tgt_ch  = 0;
   int ph      = 0;
   int ss_cnt  = 0;
   int ring_hi = 0;
   int ring_bad = 0;
   logic [3:0] ring_exp = '0;
   logic done_prev = 1'b0;

   instrumented_adder_meas_ctrl dut (
      .wb_clk_i (clk),      .wb_rst_n (rst_n),    .start    (start),
      .mode     (mode),     .chan_sel (chan_sel), .a_val    (a_val),
      .b_val    (b_val),    .window   (window),   .chain_in (chain_in),
      .s_in     (s_in),     .adder_a  (adder_a),  .adder_b  (adder_b),
      .ring_en  (ring_en),  .ext_bit  (ext_bit),  .busy     (busy),
      .done     (done),     .count    (count),    .sum_out  (sum_out),
      .overflow (overflow), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Adder model: the selected DUT's sum is combinational.
   assign s_in = adder_a + adder_b;

   // Carry-chain model, updated away from the active edge.
   always @(negedge clk) begin
      case (ch_mode)
         1: if (ring_en[tgt_ch]) begin
               chain_in[tgt_ch] = ((ph % 10) >= 5);
               ph++;
            end else begin
               chain_in = '0;
               ph = 0;
            end
         2: if (ext_bit) begin
               if (ss_cnt == 7) chain_in[tgt_ch] = 1'b1;
               ss_cnt++;
            end else begin
               chain_in = '0;
               ss_cnt = 0;
            end
         default: chain_in = '0;
      endcase
      if (ring_en != '0) begin
         ring_hi++;
         if (ring_en != ring_exp) ring_bad++;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic push_exp(input logic [23:0] cnt, input logic [7:0] tol,
                           input logic ovf, input logic [31:0] sum);
      exp_q.push_back({tol, ovf, sum, cnt});
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [64:0] e;
      int lo, hi;
      if (rst_n && done) begin
         total++;
         if (done_prev) begin
            bad++;
            $display("FAIL done_width got=2+ cycles exp=1");
         end
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done got=done exp=none count=%0d", count);
         end else begin
            e  = exp_q.pop_front();
            lo = int'(e[23:0]) - int'(e[64:57]);
            hi = int'(e[23:0]) + int'(e[64:57]);
            total++;
            if (int'(count) < lo || int'(count) > hi) begin
               bad++;
               $display("FAIL count got=%0d exp=%0d..%0d", count, lo, hi);
            end
            chk("overflow", 64'(overflow), 64'(e[56]));
            chk("sum_out", 64'(sum_out), 64'(e[55:24]));
         end
      end
      done_prev = rst_n && done;
   end

   // ---------------- driver ----------------
   task automatic run_meas(input logic m, input logic [1:0] ch, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] w, output int cyc);
      @(negedge clk);
      mode = m; chan_sel = ch; a_val = a; b_val = b; window = w; start = 1'b1;
      @(posedge clk);
      cyc = 1;
      #1 start = 1'b0;
      while (!done && cyc < 400) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      chk("done_seen", 64'(done), 64'd1);
      repeat (2) @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int k;

      // 1. reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ring_en", 64'(ring_en), 64'd0);
      chk("rst_ext_bit", 64'(ext_bit), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_sum", 64'(sum_out), 64'd0);
      chk("idle_ovf", 64'(overflow), 64'd0);
      chk("idle_adder_a", 64'(adder_a), 64'd0);
      chk("idle_adder_b", 64'(adder_b), 64'd0);
      chk("idle_state", 64'(dbg_state), 64'(IDLE));

      // 2. ring mode, chan 1, window 100, 10-clock ring period
      ch_mode = 1; tgt_ch = 1; ring_exp = 4'b0010; ring_hi = 0; ring_bad = 0;
      push_exp(24'd10, 8'd1, 1'b0, 32'd12);
      run_meas(1'b0, 2'd1, 32'd5, 32'd7, 16'd100, cyc);
      chk("ring_en_cycles", 64'(ring_hi), 64'd100);
      chk("ring_en_onehot", 64'(ring_bad), 64'd0);
      chk("ring_latency", 64'(cyc), 64'd108);

      // 3. single-shot, chain rises 7 clocks after ext_bit
      ch_mode = 2; tgt_ch = 2; ring_hi = 0;
      push_exp(24'd9, 8'd0, 1'b0, 32'h2345_6789);
      run_meas(1'b1, 2'd2, 32'h1234_5678, 32'h1111_1111, 16'd50, cyc);
      chk("ss_no_ring_en", 64'(ring_hi), 64'd0);

      // 4. single-shot timeout, window 20
      ch_mode = 0; tgt_ch = 3;
      push_exp(24'd20, 8'd0, 1'b1, 32'd300);
      run_meas(1'b1, 2'd3, 32'd100, 32'd200, 16'd20, cyc);
      chk("timeout_latency", 64'(cyc), 64'd28);

      // window 0 behaves as 1
      push_exp(24'd1, 8'd0, 1'b1, 32'd7);
      run_meas(1'b1, 2'd0, 32'd3, 32'd4, 16'd0, cyc);
      chk("win0_latency", 64'(cyc), 64'd9);

      // 5. carry-through sum, start re-pulsed mid-RUN is ignored
      ch_mode = 0;
      push_exp(24'd30, 8'd0, 1'b1, 32'd0);
      @(negedge clk);
      mode = 1'b1; chan_sel = 2'd0; a_val = 32'hFFFF_FFFF; b_val = 32'd1; window = 16'd30;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (dbg_state != RUN && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("reached_run", 64'(dbg_state), 64'(RUN));
      repeat (3) @(negedge clk);
      mode = 1'b0; window = 16'd5; a_val = 32'd9; start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("busy_in_run", 64'(busy), 64'd1);
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("busy_drops", 64'(busy), 64'd0);
      repeat (20) @(negedge clk);

      // 6. reset mid-RUN
      ch_mode = 1; tgt_ch = 1; ring_exp = 4'b0010;
      @(negedge clk);
      mode = 1'b0; chan_sel = 2'd1; a_val = 32'd1; b_val = 32'd2; window = 16'd100;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (ring_en == '0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("ring_open_before_rst", 64'(ring_en), 64'h2);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ring_en", 64'(ring_en), 64'd0);
      chk("rst_mid_state", 64'(dbg_state), 64'(IDLE));
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_sum", 64'(sum_out), 64'd0);
      chk("rst_mid_count", 64'(count), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // recovery after reset: single-shot on channel 3
      ch_mode = 2; tgt_ch = 3;
      push_exp(24'd9, 8'd0, 1'b0, 32'hA5A5_A5A4);
      run_meas(1'b1, 2'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 16'd40, cyc);
      chk("ss_latency", 64'(cyc), 64'd48);

      repeat (5) @(negedge clk);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
